// File: rtl/rect_scan_unit.sv
// Per-pixel rectangle scanner: streams every rect descriptor from a synchronous-read RAM
// and resolves the colour of the highest-index enabled rectangle containing the pixel.
module rect_scan_unit #(
    parameter int                     COORD_WIDTH = 16,
    parameter int                     COLOR_WIDTH = 16,
    parameter int                     RECT_COUNT  = 64,
    parameter int                     ADDR_WIDTH  = $clog2(RECT_COUNT),
    parameter logic [COLOR_WIDTH-1:0] BG_COLOR    = '0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   pix_valid,
    output logic                                   pix_ready,
    input  logic [COORD_WIDTH-1:0]                 pix_x,
    input  logic [COORD_WIDTH-1:0]                 pix_y,
    output logic                                   rect_rd_en,
    output logic [ADDR_WIDTH-1:0]                  rect_addr,
    input  logic [1+4*COORD_WIDTH+COLOR_WIDTH-1:0] rect_rdata,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [COLOR_WIDTH-1:0]                 out_color,
    output logic                                   out_hit
);

    localparam int                    DESC_W    = 1 + 4*COORD_WIDTH + COLOR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RECT_COUNT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, state_nx;

    logic                   vld_p0;
    logic                   last_p0;
    logic [COORD_WIDTH-1:0] x_q, y_q;
    logic                   acc_hit, acc_hit_nx;
    logic [COLOR_WIDTH-1:0] acc_color, acc_color_nx;

    logic                   desc_en;
    logic [COORD_WIDTH-1:0] desc_left, desc_top, desc_right, desc_bottom;
    logic [COLOR_WIDTH-1:0] desc_color;

    // Half-open, unsigned, full-width compare: an empty or inverted box can never hit.
    function automatic logic rect_hit(
        input logic                   en,
        input logic [COORD_WIDTH-1:0] left,
        input logic [COORD_WIDTH-1:0] top,
        input logic [COORD_WIDTH-1:0] right,
        input logic [COORD_WIDTH-1:0] bottom,
        input logic [COORD_WIDTH-1:0] x,
        input logic [COORD_WIDTH-1:0] y
    );
        return en && (left <= x) && (x < right) && (top <= y) && (y < bottom);
    endfunction

    assign desc_en     = rect_rdata[DESC_W-1];
    assign desc_left   = rect_rdata[COLOR_WIDTH+4*COORD_WIDTH-1 -: COORD_WIDTH];
    assign desc_top    = rect_rdata[COLOR_WIDTH+3*COORD_WIDTH-1 -: COORD_WIDTH];
    assign desc_right  = rect_rdata[COLOR_WIDTH+2*COORD_WIDTH-1 -: COORD_WIDTH];
    assign desc_bottom = rect_rdata[COLOR_WIDTH+COORD_WIDTH-1 -: COORD_WIDTH];
    assign desc_color  = rect_rdata[COLOR_WIDTH-1:0];

    always_comb begin
        acc_hit_nx   = acc_hit;
        acc_color_nx = acc_color;
        if (rect_hit(desc_en, desc_left, desc_top, desc_right, desc_bottom, x_q, y_q)) begin
            acc_hit_nx   = 1'b1;
            acc_color_nx = desc_color;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pix_valid)         state_nx = SCAN;
            SCAN:    if (vld_p0 && last_p0) state_nx = DONE;
            DONE:    if (out_ready)         state_nx = IDLE;
            default:                        state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pix_ready  <= 1'b1;
            rect_rd_en <= 1'b0;
            rect_addr  <= '0;
            vld_p0     <= 1'b0;
            last_p0    <= 1'b0;
            out_valid  <= 1'b0;
            out_hit    <= 1'b0;
            out_color  <= BG_COLOR;
        end else begin
            state     <= state_nx;
            pix_ready <= (state_nx == IDLE);

            // Stage p0: descriptor read issued last edge; its data is evaluated on the next edge.
            vld_p0  <= rect_rd_en;
            last_p0 <= rect_rd_en && (rect_addr == LAST_ADDR);

            if (state == IDLE && pix_valid) begin
                rect_rd_en <= 1'b1;
                rect_addr  <= '0;
            end else if (rect_rd_en) begin
                if (rect_addr == LAST_ADDR) begin
                    rect_rd_en <= 1'b0;
                    rect_addr  <= '0;
                end else begin
                    rect_addr <= rect_addr + 1'b1;
                end
            end

            if (vld_p0 && last_p0) begin
                out_valid <= 1'b1;
                out_hit   <= acc_hit_nx;
                out_color <= acc_color_nx;
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Pixel and accumulator are data only: they are (re)initialised at every accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && pix_valid && !reset) begin
            x_q       <= pix_x;
            y_q       <= pix_y;
            acc_hit   <= 1'b0;
            acc_color <= BG_COLOR;
        end else if (vld_p0) begin
            acc_hit   <= acc_hit_nx;
            acc_color <= acc_color_nx;
        end
    end

endmodule

// File: tb/tb_rect_scan_unit.sv
// Directed + randomized bench for rect_scan_unit with a behavioural RAM and painter's-order reference.
module tb_rect_scan_unit;

    localparam int          CW = 16;
    localparam int          KW = 16;
    localparam int          RC = 64;
    localparam int          AW = 6;
    localparam logic [15:0] BG = 16'h0842;

    logic              clk = 1'b0;
    logic              reset;
    logic              pix_valid;
    logic              pix_ready;
    logic [CW-1:0]     pix_x, pix_y;
    logic              rect_rd_en;
    logic [AW-1:0]     rect_addr;
    logic [1+4*CW+KW-1:0] rect_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [KW-1:0]     out_color;
    logic              out_hit;

    rect_scan_unit #(
        .COORD_WIDTH(CW), .COLOR_WIDTH(KW), .RECT_COUNT(RC), .ADDR_WIDTH(AW), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .rect_rd_en(rect_rd_en), .rect_addr(rect_addr),
        .rect_rdata(rect_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_color(out_color), .out_hit(out_hit)
    );

    always #5 clk = ~clk;

    logic          m_en [RC];
    logic [CW-1:0] m_l  [RC];
    logic [CW-1:0] m_t  [RC];
    logic [CW-1:0] m_r  [RC];
    logic [CW-1:0] m_b  [RC];
    logic [KW-1:0] m_c  [RC];
    int            rd_cnt [RC];

    initial begin
        rect_rdata = '0;
        for (int i = 0; i < RC; i++) rd_cnt[i] = 0;
    end

    always @(posedge clk) begin
        if (rect_rd_en) begin
            rect_rdata <= {m_en[rect_addr], m_l[rect_addr], m_t[rect_addr],
                           m_r[rect_addr], m_b[rect_addr], m_c[rect_addr]};
            rd_cnt[rect_addr] <= rd_cnt[rect_addr] + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: last enabled rectangle (in index order) whose half-open box holds the pixel.
    function automatic logic [KW:0] model(input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [KW:0] res = {1'b0, BG};
        for (int i = 0; i < RC; i++)
            if (m_en[i] && m_l[i] <= x && x < m_r[i] && m_t[i] <= y && y < m_b[i])
                res = {1'b1, m_c[i]};
        return res;
    endfunction

    task automatic clear_all();
        for (int i = 0; i < RC; i++) begin
            m_en[i] = 1'b0; m_l[i] = '0; m_t[i] = '0; m_r[i] = '0; m_b[i] = '0; m_c[i] = '0;
        end
    endtask

    task automatic set_rect(input int i, input logic en, input logic [CW-1:0] l, input logic [CW-1:0] t,
                            input logic [CW-1:0] r, input logic [CW-1:0] b, input logic [KW-1:0] c);
        m_en[i] = en; m_l[i] = l; m_t[i] = t; m_r[i] = r; m_b[i] = b; m_c[i] = c;
    endtask

    task automatic run_pixel(input string tag, input logic [CW-1:0] x, input logic [CW-1:0] y, input int hold);
        logic [KW:0] exp;
        int          snap [RC];
        int          cyc;
        bit          once;
        exp  = model(x, y);
        snap = rd_cnt;
        @(negedge clk);
        cyc = 0;
        while (!pix_ready && cyc < 50) begin @(negedge clk); cyc++; end
        check({tag, "_ready"}, 32'(pix_ready), 32'd1);
        out_ready = (hold == 0);
        pix_valid = 1'b1; pix_x = x; pix_y = y;
        @(posedge clk);
        #1 pix_valid = 1'b0; pix_x = 16'($urandom); pix_y = 16'($urandom);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!out_valid && cyc < RC + 20);
        check({tag, "_latency"}, 32'(cyc - 1), 32'(RC + 1));
        check({tag, "_hit"}, 32'(out_hit), 32'(exp[KW]));
        check({tag, "_color"}, 32'(out_color), 32'(exp[KW-1:0]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {12'd0, out_valid, out_hit, out_color, pix_ready, rect_rd_en},
                  {12'd0, 1'b1, exp, 1'b0, 1'b0});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_release"}, {30'd0, out_valid, pix_ready}, 32'd1);
        once = 1'b1;
        for (int i = 0; i < RC; i++) if (rd_cnt[i] - snap[i] != 1) once = 1'b0;
        check({tag, "_reads_once"}, 32'(once), 32'd1);
    endtask

    initial begin
        int  cyc;
        bit  saw;
        reset = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; out_ready = 1'b1;
        clear_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", {7'd0, pix_ready, rect_rd_en, rect_addr, out_valid, out_hit, out_color},
              {7'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, BG});
        reset = 1'b0;

        // T1: reset mid-scan drops the pixel
        set_rect(5, 1'b1, 16'd0, 16'd0, 16'd100, 16'd100, 16'hABCD);
        @(negedge clk);
        pix_valid = 1'b1; pix_x = 16'd5; pix_y = 16'd5;
        @(posedge clk);
        #1 pix_valid = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (rect_addr != 6'd10 && cyc < 40);
        check("t1_reach_k10", 32'(rect_addr), 32'd10);
        reset = 1'b1;
        @(negedge clk);
        check("t1_after_rst", {28'd0, out_valid, pix_ready, rect_rd_en, 1'b0}, {28'd0, 4'b0100});
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (RC + 5) begin @(negedge clk); if (out_valid) saw = 1'b1; end
        check("t1_no_result", 32'(saw), 32'd0);
        run_pixel("t1_new", 16'd5, 16'd5, 0);

        // T2: nothing enabled
        clear_all();
        run_pixel("t2_nohit", 16'd5, 16'd5, 0);

        // T3: edges of a single rectangle
        set_rect(0, 1'b1, 16'd10, 16'd10, 16'd20, 16'd20, 16'hF800);
        run_pixel("t3_tl", 16'd10, 16'd10, 0);
        run_pixel("t3_br", 16'd19, 16'd19, 0);
        run_pixel("t3_xr", 16'd20, 16'd15, 0);
        run_pixel("t3_yb", 16'd15, 16'd20, 0);
        run_pixel("t3_xl", 16'd9, 16'd15, 0);

        // T4: priority
        clear_all();
        set_rect(3, 1'b1, 16'd0, 16'd0, 16'd100, 16'd100, 16'h001F);
        set_rect(7, 1'b1, 16'd50, 16'd50, 16'd60, 16'd60, 16'h07E0);
        run_pixel("t4_top", 16'd55, 16'd55, 0);
        m_en[7] = 1'b0;
        run_pixel("t4_dis", 16'd55, 16'd55, 0);

        // T5: degenerate boxes, plus the all-ones coordinate
        clear_all();
        set_rect(1, 1'b1, 16'd30, 16'd30, 16'd30, 16'd40, 16'h1111);
        set_rect(2, 1'b1, 16'd40, 16'd10, 16'd30, 16'd20, 16'h2222);
        run_pixel("t5_zero_w", 16'd30, 16'd35, 0);
        run_pixel("t5_invert", 16'd35, 16'd15, 0);
        set_rect(9, 1'b1, 16'hFFF0, 16'hFFF0, 16'hFFFF, 16'hFFFF, 16'h3333);
        run_pixel("t5_maxmiss", 16'hFFFF, 16'hFFF5, 0);
        run_pixel("t5_maxhit", 16'hFFFE, 16'hFFFE, 0);

        // T6: backpressure
        run_pixel("t6_hold", 16'hFFF8, 16'hFFF1, 20);
        run_pixel("t6_next", 16'd35, 16'd15, 0);

        // Randomized scenes in a small coordinate range so hits are common
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < RC; i++)
                set_rect(i, 1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 63)),
                         16'($urandom_range(0, 63)), 16'($urandom_range(0, 63)),
                         16'($urandom_range(0, 63)), 16'($urandom));
            run_pixel("rand", 16'($urandom_range(0, 63)), 16'($urandom_range(0, 63)),
                      int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
